// File: rtl/bus_protocol_master.sv
// bus_protocol_master: master-side driver for the dValid/dAck/data bus.
// Buffers upstream bytes in a small FIFO and presents each one on the bus,
// holding dValid for 2..4 cycles and dropping it the cycle after an accepted ack.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   in_valid/in_ready/in_data      - upstream valid/ready byte source
//   dValid/data/dAck               - bus handshake and payload
//   xfer_done/timeout_err/early_ack_err - single-cycle status pulses
//   xfer_cnt/err_cnt               - accepted words (wraps), timeouts (saturates)
module bus_protocol_master #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             dValid,
  output logic [7:0]       data,
  input  logic             dAck,
  output logic             xfer_done,
  output logic             timeout_err,
  output logic             early_ack_err,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [7:0]     mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [2:0]     k;
  logic           empty;
  logic           full;
  logic           push;
  logic           accept;
  logic           timeout_hit;
  logic           early_hit;
  logic           load;
  logic           pop;
  logic           dvalid_nxt;
  logic           xfer_done_nxt;
  logic           timeout_nxt;
  logic           early_nxt;

  // FIFO status; the head stays occupied until its transfer ends
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full && !reset;
  assign push     = in_valid && in_ready;

  // Ack classification for the current DRIVE cycle
  assign early_hit   = (state == DRIVE) && dAck && (k == 3'd1);
  assign accept      = (state == DRIVE) && dAck && (k >= 3'd2);
  assign timeout_hit = (state == DRIVE) && !dAck && (k == 3'd4);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = DRIVE;
      DRIVE:   if (accept || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and FIFO controls
  always_comb begin
    dvalid_nxt    = 1'b0;
    xfer_done_nxt = 1'b0;
    timeout_nxt   = 1'b0;
    early_nxt     = 1'b0;
    load          = 1'b0;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        load       = !empty;
        dvalid_nxt = !empty;
      end
      DRIVE: begin
        pop           = accept || timeout_hit;
        dvalid_nxt    = !(accept || timeout_hit);
        xfer_done_nxt = accept;
        timeout_nxt   = timeout_hit;
        early_nxt     = early_hit;
      end
      default: ;
    endcase
  end

  // FIFO storage (no reset needed; only read after a write)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  // Datapath, pointers, cycle counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      k             <= 3'd0;
      dValid        <= 1'b0;
      data          <= 8'h00;
      xfer_done     <= 1'b0;
      timeout_err   <= 1'b0;
      early_ack_err <= 1'b0;
      xfer_cnt      <= '0;
      err_cnt       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);

      // k counts dValid-high cycles; an early ack simply advances it to 2
      if (load)                 k <= 3'd1;
      else if (state == DRIVE && !pop) k <= k + 3'd1;

      if (load) data <= mem[rd_ptr[AW-1:0]];

      dValid        <= dvalid_nxt;
      xfer_done     <= xfer_done_nxt;
      timeout_err   <= timeout_nxt;
      early_ack_err <= early_nxt;

      if (xfer_done_nxt) xfer_cnt <= xfer_cnt + CNT_W'(1);
      if (timeout_nxt && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bus_protocol_master.sv
// tb_bus_protocol_master: scoreboard bench for bus_protocol_master.
// Pushed words queue their expected bus behaviour; a negedge monitor pops and
// checks each word when it appears on the bus, and also drives dAck.
module tb_bus_protocol_master;

  localparam int unsigned CNT_W = 16;

  typedef struct {
    logic [7:0] data;
    int         high;
    bit         timeout;
    int         early;
    int         gap;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             dValid;
  logic [7:0]       data;
  logic             dAck;
  logic             xfer_done;
  logic             timeout_err;
  logic             early_ack_err;
  logic [CNT_W-1:0] xfer_cnt;
  logic [CNT_W-1:0] err_cnt;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   ack_at   = 0;
  bit   ack_always = 1'b0;
  int   exp_xfer = 0;
  int   exp_err  = 0;

  bus_protocol_master #(.DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .dValid        (dValid),
    .data          (data),
    .dAck          (dAck),
    .xfer_done     (xfer_done),
    .timeout_err   (timeout_err),
    .early_ack_err (early_ack_err),
    .xfer_cnt      (xfer_cnt),
    .err_cnt       (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one word upstream; waits (bounded) for in_ready, then queues expectations
  task automatic push(input logic [7:0] d, input int high, input bit tmo,
                      input int early, input int gap);
    exp_t e;
    int   n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("push_ready", 32'(in_ready), 32'd1);
    e.data = d; e.high = high; e.timeout = tmo; e.early = early; e.gap = gap;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_xfer_cnt"}, 32'(xfer_cnt), 32'(exp_xfer));
    check({tag, "_err_cnt"},  32'(err_cnt),  32'(exp_err));
  endtask

  // Bus monitor and dAck driver
  initial begin : monitor
    exp_t cur;
    int   run;
    int   low;
    int   early_seen;
    cur.data = 8'h00; cur.high = 0; cur.timeout = 1'b0; cur.early = 0; cur.gap = 0;
    run = 0; low = 0; early_seen = 0;
    dAck = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        run = 0;
        low = 0;
        early_seen = 0;
      end else if (dValid) begin
        if (run == 0) begin
          check("sb_avail", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            cur = sb.pop_front();
            check("data_first", 32'(data), 32'(cur.data));
            if (cur.gap != 0) check("low_gap", 32'(low), 32'(cur.gap));
          end
          early_seen = 0;
        end else begin
          check("data_stable", 32'(data), 32'(cur.data));
        end
        run++;
        if (early_ack_err) early_seen++;
      end else begin
        if (run != 0) begin
          check("high_len",  32'(run),         32'(cur.high));
          check("xfer_done", 32'(xfer_done),   32'(!cur.timeout));
          check("timeout",   32'(timeout_err), 32'(cur.timeout));
          check("early_cnt", 32'(early_seen),  32'(cur.early));
          low = 0;
        end
        run = 0;
        low++;
      end
      dAck = ack_always || (dValid && !reset && run == ack_at);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int n;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_dvalid",   32'(dValid),        32'd0);
    check("rst_data",     32'(data),          32'h00);
    check("rst_in_ready", 32'(in_ready),      32'd0);
    check("rst_pulses",   32'({xfer_done, timeout_err, early_ack_err}), 32'd0);
    check_counters("rst");
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // Basic: ack on the 2nd high cycle
    ack_at = 2; ack_always = 1'b0;
    push(8'hA5, 2, 1'b0, 0, 0);
    repeat (8) @(posedge clk); #1;
    exp_xfer++;
    check_counters("basic");

    // Late ack on the 4th high cycle
    ack_at = 4;
    push(8'h3C, 4, 1'b0, 0, 0);
    repeat (8) @(posedge clk); #1;
    exp_xfer++;
    check_counters("late");

    // Timeout: never ack
    ack_at = 0;
    push(8'h11, 4, 1'b1, 0, 0);
    repeat (8) @(posedge clk); #1;
    exp_err++;
    check_counters("timeout");
    check("timeout_empty", 32'(in_ready), 32'd1);

    // Early ack, back-to-back words with dAck held high
    ack_always = 1'b1;
    push(8'h01, 2, 1'b0, 1, 0);
    push(8'h02, 2, 1'b0, 1, 1);
    repeat (10) @(posedge clk); #1;
    exp_xfer += 2;
    check_counters("b2b");
    check("b2b_sb_drained", 32'(sb.size()), 32'd0);

    // Full FIFO, then reset during DRIVE
    ack_always = 1'b0; ack_at = 0;
    push(8'h51, 4, 1'b1, 0, 0);
    push(8'h52, 2, 1'b0, 0, 0);
    check("full_ready0", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("full_ready0_hold", 32'(in_ready), 32'd0);
    push(8'h53, 2, 1'b0, 0, 0);
    n = 0;
    while (!dValid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("w2_drive", 32'(dValid), 32'd1);
    check("w2_data", 32'(data), 32'h52);
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    exp_xfer = 0; exp_err = 0;
    check("mid_rst_dvalid", 32'(dValid),   32'd0);
    check("mid_rst_data",   32'(data),     32'h00);
    check("mid_rst_ready",  32'(in_ready), 32'd0);
    check("mid_rst_pulses", 32'({xfer_done, timeout_err, early_ack_err}), 32'd0);
    check_counters("mid_rst");
    reset = 1'b0;
    @(posedge clk); #1;
    check("flush_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("flush_idle", 32'({dValid, xfer_done, timeout_err, early_ack_err}), 32'd0);
      @(posedge clk); #1;
    end
    check_counters("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
